// File: rtl/nfa_pkg.sv
// Shared types and constants for the NFA scan controller.
// The optional early-exit feature is selected by the NFA_SCAN_EARLY_EXIT_EN macro.
package nfa_pkg;

   localparam int unsigned NFA_LAT_DEF    = 3;
   localparam int unsigned OFF_W_DEF      = 16;
   localparam logic [7:0]  NFA_FLUSH_BYTE = 8'h00;

   typedef logic [2:0] nfa_state_t;

   localparam nfa_state_t ST_IDLE    = 3'd0;
   localparam nfa_state_t ST_SCAN    = 3'd1;
   localparam nfa_state_t ST_DISCARD = 3'd2;
   localparam nfa_state_t ST_DRAIN   = 3'd3;
   localparam nfa_state_t ST_REPORT  = 3'd4;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/nfa_scan_ctrl_if.sv
// Byte-stream input and result handshakes of the scan controller.
// master = packet source / result sink, slave = nfa_scan_ctrl.
interface nfa_scan_ctrl_if
   import nfa_pkg::*;
#(
   parameter int unsigned OFF_W = OFF_W_DEF
);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic             in_sop;
   logic             in_eop;
   logic             res_valid;
   logic             res_ready;
   logic             res_match;
   logic [OFF_W-1:0] res_offset;
   logic [7:0]       res_count;
   logic             res_err;

   modport master (
      output in_valid, in_data, in_sop, in_eop, res_ready,
      input  in_ready, res_valid, res_match, res_offset, res_count, res_err
   );

   modport slave (
      input  in_valid, in_data, in_sop, in_eop, res_ready,
      output in_ready, res_valid, res_match, res_offset, res_count, res_err
   );
endinterface

// File: rtl/nfa_scan_ctrl_tag_pipe.sv
// DEPTH-stage {valid, offset} delay line that tracks each launched byte until
// its match response returns from the chain.
module nfa_tag_pipe #(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned OFF_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_vld,
   input  logic [OFF_W-1:0] i_off,
   output logic             o_vld,
   output logic [OFF_W-1:0] o_off
);

   logic [DEPTH-1:0] r_vld;
   logic [OFF_W-1:0] r_off [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_vld <= '0;
         for (int i = 0; i < int'(DEPTH); i++) r_off[i] <= '0;
      end else begin
         r_vld[0] <= i_vld;
         r_off[0] <= i_off;
         for (int i = 1; i < int'(DEPTH); i++) begin
            r_vld[i] <= r_vld[i-1];
            r_off[i] <= r_off[i-1];
         end
      end
   end

   assign o_vld = r_vld[DEPTH-1];
   assign o_off = r_off[DEPTH-1];

endmodule

// File: rtl/nfa_scan_ctrl.sv
// Packet scan controller feeding the NFA chain and reporting one result per packet.
// Define NFA_SCAN_EARLY_EXIT_EN to stop scanning a packet after its first match.
module nfa_scan_ctrl
   import nfa_pkg::*;
#(
   parameter int unsigned NFA_LAT  = NFA_LAT_DEF,
   parameter int unsigned OFF_W    = OFF_W_DEF,
   parameter bit          ANCHORED = 1'b0
) (
   input  logic           i_clk,
   input  logic           i_reset,
   nfa_scan_ctrl_if.slave bus,
   output logic           o_nfa_en,
   output logic [7:0]     o_nfa_payload,
   input  logic           i_nfa_match,
   output logic           o_busy
);

   localparam int unsigned DW = $clog2(NFA_LAT + 1) + 1;

   nfa_state_t       r_state;
   nfa_state_t       w_state_d;
   logic [OFF_W-1:0] r_cnt;
   logic [7:0]       r_payload;
   logic             r_en;
   logic             r_lv;
   logic [OFF_W-1:0] r_loff;
   logic [DW-1:0]    r_drain;
   logic             r_match;
   logic [OFF_W-1:0] r_off;
   logic [7:0]       r_count;
   logic             r_err;
   logic             r_res_valid;

   logic             w_launch;
   logic             w_set_err;
   logic             w_done;
   logic             w_hit;
   logic             w_tail_vld;
   logic [OFF_W-1:0] w_tail_off;
   logic [OFF_W-1:0] w_off_now;

   // Tag stage 0 (r_lv/r_loff) is aligned with o_nfa_payload; the pipe adds NFA_LAT more.
   nfa_tag_pipe #(
      .DEPTH (NFA_LAT),
      .OFF_W (OFF_W)
   ) u_tag_pipe (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (w_done),
      .i_vld   (r_lv),
      .i_off   (r_loff),
      .o_vld   (w_tail_vld),
      .o_off   (w_tail_off)
   );

   assign w_hit     = i_nfa_match & w_tail_vld;
   assign w_done    = (r_state == ST_REPORT) && r_res_valid && bus.res_ready;
   assign w_off_now = (r_state == ST_IDLE) ? '0 : r_cnt;

   always_comb begin
      w_state_d = r_state;
      w_launch  = 1'b0;
      w_set_err = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid && bus.in_sop) begin
               w_launch  = 1'b1;
               w_state_d = bus.in_eop ? ST_DRAIN : ST_SCAN;
            end
         end
         ST_SCAN: begin
            // The chain cannot stall, so a gap ends the packet with an error.
            if (!bus.in_valid) begin
               w_set_err = 1'b1;
               w_state_d = ST_DRAIN;
            end else begin
               w_launch = 1'b1;
               if (bus.in_sop) begin
                  w_set_err = 1'b1;
                  w_state_d = ST_DRAIN;
               end else if (bus.in_eop) begin
                  w_state_d = ST_DRAIN;
               end
`ifdef NFA_SCAN_EARLY_EXIT_EN
               else if (w_hit && !r_match) begin
                  w_state_d = ST_DISCARD;
               end
`endif
            end
         end
`ifdef NFA_SCAN_EARLY_EXIT_EN
         ST_DISCARD: begin
            if (bus.in_valid && bus.in_eop) w_state_d = ST_DRAIN;
         end
`endif
         ST_DRAIN: begin
            if (r_drain == DW'(NFA_LAT)) w_state_d = ST_REPORT;
         end
         ST_REPORT: begin
            if (w_done) w_state_d = ST_IDLE;
         end
         default: w_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_payload   <= NFA_FLUSH_BYTE;
         r_en        <= 1'b0;
         r_lv        <= 1'b0;
         r_loff      <= '0;
         r_drain     <= '0;
         r_match     <= 1'b0;
         r_off       <= '0;
         r_count     <= '0;
         r_err       <= 1'b0;
         r_res_valid <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_payload <= w_launch ? bus.in_data : NFA_FLUSH_BYTE;
         r_en      <= w_launch && ((ANCHORED == 1'b0) || bus.in_sop);
         r_lv      <= w_launch;
         r_loff    <= w_launch ? w_off_now : '0;
         r_drain   <= (r_state == ST_DRAIN) ? r_drain + DW'(1) : '0;
         if (w_launch) begin
            if (r_state == ST_IDLE) r_cnt <= OFF_W'(1);
            else if (r_cnt != {OFF_W{1'b1}}) r_cnt <= r_cnt + OFF_W'(1);
         end
         if (w_set_err) r_err <= 1'b1;
         if (w_hit) begin
            r_count <= sat_inc8(r_count);
            if (!r_match) begin
               r_match <= 1'b1;
               r_off   <= w_tail_off;
            end
         end
         if (r_state == ST_REPORT) r_res_valid <= 1'b1;
         if (w_done) begin
            r_cnt       <= '0;
            r_match     <= 1'b0;
            r_off       <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_res_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready   = !i_reset && ((r_state == ST_IDLE) || (r_state == ST_SCAN) ||
                                        (r_state == ST_DISCARD));
   assign bus.res_valid  = r_res_valid;
   assign bus.res_match  = r_res_valid & r_match;
   assign bus.res_offset = r_res_valid ? r_off : '0;
   assign bus.res_count  = r_res_valid ? r_count : 8'h00;
   assign bus.res_err    = r_res_valid & r_err;

   assign o_nfa_en      = r_en;
   assign o_nfa_payload = r_payload;
   assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_nfa_scan_ctrl.sv
// Bench for nfa_scan_ctrl: an unanchored and an anchored instance share one stimulus,
// each driven by a behavioural chain that matches "ab" NFA_LAT cycles after the 'b'.
module tb_nfa_scan_ctrl;

   localparam int L = 3;

   logic clk;
   logic reset;
   logic in_valid, in_sop, in_eop, res_ready;
   logic [7:0] in_data;

   logic       en0, en1, match0, match1, busy0, busy1;
   logic [7:0] pay0, pay1;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int t0 = 0;
   bit count_en = 1'b0;
   int en_hits = 0;

   nfa_scan_ctrl_if #(.OFF_W(16)) u_if0 ();
   nfa_scan_ctrl_if #(.OFF_W(16)) u_if1 ();

   assign u_if0.in_valid  = in_valid;
   assign u_if0.in_data   = in_data;
   assign u_if0.in_sop    = in_sop;
   assign u_if0.in_eop    = in_eop;
   assign u_if0.res_ready = res_ready;
   assign u_if1.in_valid  = in_valid;
   assign u_if1.in_data   = in_data;
   assign u_if1.in_sop    = in_sop;
   assign u_if1.in_eop    = in_eop;
   assign u_if1.res_ready = res_ready;

   nfa_scan_ctrl #(.NFA_LAT(L), .OFF_W(16), .ANCHORED(1'b0)) u_dut0 (
      .i_clk(clk), .i_reset(reset), .bus(u_if0), .o_nfa_en(en0), .o_nfa_payload(pay0),
      .i_nfa_match(match0), .o_busy(busy0)
   );

   nfa_scan_ctrl #(.NFA_LAT(L), .OFF_W(16), .ANCHORED(1'b1)) u_dut1 (
      .i_clk(clk), .i_reset(reset), .bus(u_if1), .o_nfa_en(en1), .o_nfa_payload(pay1),
      .i_nfa_match(match1), .o_busy(busy1)
   );

   // Chain models are never reset, so stale matches after a reset reach the DUT.
   logic         m0_thr = 1'b0, m1_thr = 1'b0;
   logic [L-1:0] m0_dl = '0, m1_dl = '0;

   always @(posedge clk) begin
      m0_thr <= en0 && (pay0 == 8'h61);
      m0_dl  <= {m0_dl[L-2:0], m0_thr && (pay0 == 8'h62)};
      m1_thr <= en1 && (pay1 == 8'h61);
      m1_dl  <= {m1_dl[L-2:0], m1_thr && (pay1 == 8'h62)};
   end
   assign match0 = m0_dl[L-1];
   assign match1 = m1_dl[L-1];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (count_en && en0) en_hits <= en_hits + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string s;
      bit    bad;
      bit    m0;
      int    off0;
      int    cnt0;
      bit    m1;
      int    off1;
      int    cnt1;
      bit    err;
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mk(input string s, input bit bad, input bit m0, input int off0,
                               input int cnt0, input bit m1, input int off1, input int cnt1,
                               input bit err);
      vec_t v;
      v.s = s; v.bad = bad; v.m0 = m0; v.off0 = off0; v.cnt0 = cnt0;
      v.m1 = m1; v.off1 = off1; v.cnt1 = cnt1; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input string s, input bit bad);
      int n = s.len();
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = s[i];
         in_sop   = (i == 0) || (bad && (i == n - 1));
         in_eop   = (i == n - 1) && !bad;
         if (i == 0) t0 = cyc;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h00;
   endtask

   task automatic wait_res(output int lat);
      lat = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (u_if0.res_valid === 1'b1) begin
            lat = cyc - t0;
            break;
         end
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL res_timeout: got no res_valid expected res_valid within 60 cycles");
      end
   endtask

   task automatic ack();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   int lat;

   initial begin
      vecs[0] = mk("xxab", 0, 1, 3, 1, 0, 0, 0, 0);
      vecs[1] = mk("xab",  0, 1, 2, 1, 0, 0, 0, 0);
      vecs[2] = mk("abx",  0, 1, 1, 1, 1, 1, 1, 0);
      vecs[3] = mk("abab", 0, 1, 1, 2, 1, 1, 1, 0);
      vecs[4] = mk("a",    0, 0, 0, 0, 0, 0, 0, 0);
      vecs[5] = mk("b",    0, 0, 0, 0, 0, 0, 0, 0);
      vecs[6] = mk("aab",  0, 1, 2, 1, 0, 0, 0, 0);
      vecs[7] = mk("ab",   1, 1, 1, 1, 1, 1, 1, 1);

      reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h00;
      res_ready = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", u_if0.in_ready, 0);
      chk("rst_nfa_en", en0, 0);
      chk("rst_payload", pay0, 0);
      chk("rst_res_valid", u_if0.res_valid, 0);
      chk("rst_res_count", u_if0.res_count, 0);
      chk("rst_busy", busy0, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", u_if0.in_ready, 1);
      chk("idle_busy", busy0, 0);

      // Launch latency on a single-byte packet
      @(posedge clk); #1;
      in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_data = 8'h71; t0 = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h00;
      @(negedge clk);
      chk("launch_payload", pay0, 8'h71);
      chk("launch_en0", en0, 1);
      chk("launch_en1", en1, 1);
      chk("launch_busy", busy0, 1);
      chk("drain_in_ready", u_if0.in_ready, 0);
      wait_res(lat);
      chk("single_latency", lat, L + 3);
      ack();

      for (int v = 0; v < 8; v++) begin
         send(vecs[v].s, vecs[v].bad);
         wait_res(lat);
         chk($sformatf("v%0d_latency", v), lat, vecs[v].s.len() + L + 2);
         chk($sformatf("v%0d_match0", v), u_if0.res_match, vecs[v].m0);
         chk($sformatf("v%0d_offset0", v), u_if0.res_offset, vecs[v].off0);
         chk($sformatf("v%0d_count0", v), u_if0.res_count, vecs[v].cnt0);
         chk($sformatf("v%0d_err0", v), u_if0.res_err, vecs[v].err);
         chk($sformatf("v%0d_valid1", v), u_if1.res_valid, 1);
         chk($sformatf("v%0d_match1", v), u_if1.res_match, vecs[v].m1);
         chk($sformatf("v%0d_offset1", v), u_if1.res_offset, vecs[v].off1);
         chk($sformatf("v%0d_count1", v), u_if1.res_count, vecs[v].cnt1);
         chk($sformatf("v%0d_err1", v), u_if1.res_err, vecs[v].err);
         ack();
         @(negedge clk);
         chk($sformatf("v%0d_idle", v), busy0, 0);
      end

      // Gap at byte 2: err, then in_ready low through the drain window
      @(posedge clk); #1;
      in_valid = 1'b1; in_sop = 1'b1; in_data = 8'h78; t0 = cyc;
      @(posedge clk); #1;
      in_sop = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 8'h00;
      @(negedge clk);
      chk("gap_scan_ready", u_if0.in_ready, 1);
      for (int k = 0; k <= L; k++) begin
         @(negedge clk);
         chk($sformatf("gap_drain_ready%0d", k), u_if0.in_ready, 0);
         chk($sformatf("gap_drain_valid%0d", k), u_if0.res_valid, 0);
      end
      wait_res(lat);
      chk("gap_latency", lat, 3 + L + 2);
      chk("gap_err", u_if0.res_err, 1);
      chk("gap_match", u_if0.res_match, 0);
      chk("gap_count", u_if0.res_count, 0);
      ack();

      // Result backpressure with a sop waiting, then back-to-back acceptance
      send("xxab", 1'b0);
      wait_res(lat);
      in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_data = 8'h61;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("bp_valid%0d", k), u_if0.res_valid, 1);
         chk($sformatf("bp_match%0d", k), u_if0.res_match, 1);
         chk($sformatf("bp_offset%0d", k), u_if0.res_offset, 3);
         chk($sformatf("bp_count%0d", k), u_if0.res_count, 1);
         chk($sformatf("bp_in_ready%0d", k), u_if0.in_ready, 0);
         @(negedge clk);
      end
      ack();
      t0 = cyc;
      @(negedge clk);
      chk("b2b_ready", u_if0.in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h00;
      @(negedge clk);
      chk("b2b_busy", busy0, 1);
      chk("b2b_payload", pay0, 8'h61);
      wait_res(lat);
      chk("b2b_latency", lat, L + 3);
      chk("b2b_count", u_if0.res_count, 0);
      ack();

      // Reset during SCAN with a match still in flight
      @(posedge clk); #1;
      in_valid = 1'b1; in_sop = 1'b1; in_data = 8'h61; t0 = cyc;
      @(posedge clk); #1;
      in_sop = 1'b0; in_data = 8'h62;
      @(posedge clk); #1;
      in_data = 8'h61;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 8'h00; reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", u_if0.in_ready, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_res_valid", u_if0.res_valid, 0);
      chk("post_rst_en", en0, 0);
      chk("post_rst_busy", busy0, 0);
      send("ab", 1'b0);
      wait_res(lat);
      chk("post_rst_latency", lat, 2 + L + 2);
      chk("post_rst_match", u_if0.res_match, 1);
      chk("post_rst_offset", u_if0.res_offset, 1);
      chk("post_rst_count", u_if0.res_count, 1);
      chk("post_rst_err", u_if0.res_err, 0);
      ack();

`ifdef NFA_SCAN_EARLY_EXIT_EN
      count_en = 1'b1;
      send("abababab", 1'b0);
      wait_res(lat);
      count_en = 1'b0;
      chk("ee_count_le3", (u_if0.res_count <= 8'd3), 1);
      chk("ee_offset", u_if0.res_offset, 1);
      chk("ee_en_bytes", en_hits, 6);
      ack();
`endif

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
